// File: rtl/seq_sreg_pkg.sv
// Shared types and constants for the seq_sreg shift-register family.
package seq_sreg_pkg;

  // Transmitter FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default word width of the SISO chain.
  localparam int SREG_NBITS = 8;

  // Width of a counter that must hold values 0 .. nbits-1 (at least 1 bit).
  function automatic int cnt_width(input int nbits);
    return (nbits <= 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/seq_sreg_piso_shreg.sv
// Load/shift register: parallel load, shift towards the MSB, MSB exposed.
// Load takes priority over shift in the same cycle.
module seq_sreg_piso_shreg
  import seq_sreg_pkg::*;
#(
  parameter int NBITS = SREG_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] load_data,
  input  logic             shift,
  output logic             msb
);

  logic [NBITS-1:0] sreg_reg;

  // Register: clear on reset, load a new word, or shift left filling with 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_reg <= '0;
    end else if (load) begin
      sreg_reg <= load_data;
    end else if (shift) begin
      sreg_reg <= {sreg_reg[NBITS-2:0], 1'b0};
    end
  end

  assign msb = sreg_reg[NBITS-1];

endmodule

// File: rtl/seq_sreg_piso_tx.sv
// Parallel-in serial-out transmitter feeding a SISO shift-register chain.
// Words arrive on in_val/in_rdy and leave MSB first on out_val/out_rdy.
// Optional macro SEQ_SREG_PISO_TX_PARITY_EN appends an even-parity bit
// to every frame (NBITS+1 bits, out_last on the parity bit).
module seq_sreg_piso_tx
  import seq_sreg_pkg::*;
#(
  parameter int NBITS = SREG_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_bit,
  output logic             out_last
);

`ifdef SEQ_SREG_PISO_TX_PARITY_EN
  localparam int FRAME = NBITS + 1;
`else
  localparam int FRAME = NBITS;
`endif
  localparam int CW = cnt_width(FRAME);
  localparam logic [CW-1:0] CNT_FIRST = CW'(FRAME - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          load;
  logic          shift;
  logic          msb;

  seq_sreg_piso_shreg #(
    .NBITS(NBITS)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (in_data),
    .shift     (shift),
    .msb       (msb)
  );

`ifdef SEQ_SREG_PISO_TX_PARITY_EN
  logic par_reg;

  // Even parity of the accepted word, captured together with the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_reg <= 1'b0;
    end else if (load) begin
      par_reg <= ^in_data;
    end
  end
`endif

  // FSM state and bit counter (counts down to 0 on the frame's last bit).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, handshakes and serial outputs; everything is forced low
  // while reset is high so an aborted frame never leaks a bit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    shift      = 1'b0;
    in_rdy     = 1'b0;
    out_val    = 1'b0;
    out_bit    = 1'b0;
    out_last   = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          in_rdy = 1'b1;
          if (in_val) begin
            load       = 1'b1;
            cnt_next   = CNT_FIRST;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          out_val  = 1'b1;
          out_last = (cnt_reg == '0);
`ifdef SEQ_SREG_PISO_TX_PARITY_EN
          out_bit  = (cnt_reg == '0) ? par_reg : msb;
`else
          out_bit  = msb;
`endif
          if (out_rdy) begin
            shift = 1'b1;
            if (out_last) begin
              // Final bit leaves this cycle: accept the next word with no bubble.
              in_rdy = 1'b1;
              if (in_val) begin
                load     = 1'b1;
                cnt_next = CNT_FIRST;
              end else begin
                state_next = IDLE;
              end
            end else begin
              cnt_next = cnt_reg - CW'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sreg_piso_tx.sv
// Self-checking bench for seq_sreg_piso_tx: a bit-queue reference model,
// a loopback SISO register, directed scenarios and a random phase.
module tb_seq_sreg_piso_tx;

  localparam int NBITS = 8;
`ifdef SEQ_SREG_PISO_TX_PARITY_EN
  localparam int FRAME = NBITS + 1;
`else
  localparam int FRAME = NBITS;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_data;
  logic             out_val;
  logic             out_rdy;
  logic             out_bit;
  logic             out_last;
  logic [NBITS-1:0] siso;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  seq_sreg_piso_tx #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_bit  (out_bit),
    .out_last (out_last)
  );

  // Downstream SISO receiver: one shift per transferred bit.
  always @(posedge clk) begin
    if (reset) siso <= '0;
    else if (out_val && out_rdy) siso <= {siso[NBITS-2:0], out_bit};
  end

  function automatic logic [NBITS-1:0] siso_exp(input logic [NBITS-1:0] w);
`ifdef SEQ_SREG_PISO_TX_PARITY_EN
    return {w[NBITS-2:0], ^w};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [NBITS-1:0] got, input logic [NBITS-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic cycle(input logic v, input logic [NBITS-1:0] d, input logic r, input logic rst);
    logic ev, er, eb, el;
    bit   xfer, acc;
    reset = rst; in_val = v; in_data = d; out_rdy = r;
    @(negedge clk);
    if (rst) begin
      ev = 0; er = 0; eb = 0; el = 0;
    end else begin
      ev = (exp_q.size() != 0);
      el = (exp_q.size() == 1);
      eb = ev ? exp_q[0] : 1'b0;
      er = !ev || (el && r);
    end
    chk("out_val", out_val, ev);
    chk("in_rdy", in_rdy, er);
    chk("out_bit", out_bit, eb);
    chk("out_last", out_last, el);
    xfer = !rst && ev && r;
    acc  = !rst && v && er;
    out_rdy = !r;
    #1;
    chk("out_val_vs_out_rdy", out_val, ev);
    out_rdy = r;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = NBITS - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SEQ_SREG_PISO_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        $display("accept word=%0h t=%0t", d, $time);
      end
    end
    #1;
  endtask

  // Run until the model has no bits outstanding; mode 0 ready, 1 alternate, 2 random.
  task automatic drain(input int mode, input int cap);
    logic r;
    for (int i = 0; i < cap && exp_q.size() != 0; i++) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(i % 2) : logic'($urandom_range(0, 1));
      cycle(1'b0, NBITS'($urandom), r, 1'b0);
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic send_check(input logic [NBITS-1:0] w, input int mode);
    cycle(1'b1, w, 1'b1, 1'b0);
    drain(mode, 200);
    chk("loopback", siso, siso_exp(w));
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in_data = '0; out_rdy = 1'b1;
    // Reset: outputs low, in_rdy low.
    cycle(1'b1, 8'hAA, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Single word, always ready.
    send_check(8'hA5, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-to-back: second word offered continuously, taken on the last bit.
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 8'h00, 1'b1, 1'b0);
    chk("b2b_first", siso, siso_exp(8'hFF));
    drain(0, 100);
    chk("b2b_second", siso, siso_exp(8'h00));

    // Backpressure every other cycle.
    send_check(8'h81, 1);

    // Reset mid-frame, then a clean word.
    cycle(1'b1, 8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, NBITS'($urandom), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    send_check(8'h3C, 0);

    // Loopback into SISO with random backpressure.
    send_check(8'h5A, 2);

`ifdef SEQ_SREG_PISO_TX_PARITY_EN
    send_check(8'h07, 0);
    chk("parity_07", siso[0], 1'b1);
    send_check(8'h03, 0);
    chk("parity_03", siso[0], 1'b0);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      cycle(logic'($urandom_range(0, 1)), NBITS'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
    drain(2, 200);
    send_check(NBITS'($urandom), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_sreg_piso_tx.md
Name: seq_sreg_piso_tx

Overview:
- Parallel-in serial-out transmitter that drives the serial input of an 8-bit SISO shift-register chain.
- Accepts an NBITS word on a val/rdy handshake and shifts it out MSB first, one bit per transfer, with a valid/ready serial handshake.
- Downstream, each transferred bit maps onto one shift-enable pulse. After NBITS transfers, a SISO receiver holds the word with bit NBITS-1 at its output end.

Parameters:
- NBITS, 8, word width in bits; must be >= 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_val  input  1  parallel word valid
- in_rdy  output  1  transmitter can accept a word
- in_data  input  NBITS  parallel word
- out_val  output  1  out_bit is valid (downstream shift enable)
- out_rdy  input  1  downstream accepts bit
- out_bit  output  1  serial data bit
- out_last  output  1  current bit is the final bit of the frame

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- State: IDLE, SHIFT. Registers: shift register sreg[NBITS-1:0], bit counter cnt of width $clog2(NBITS).
- Reset: state=IDLE, sreg=0, cnt=0. Outputs: out_val=0, out_bit=0, out_last=0, in_rdy=0 while reset is high.
- IDLE:
  - in_rdy=1, out_val=0, out_bit=0.
  - On in_val, load sreg=in_data, set cnt=NBITS-1, go to SHIFT.
  - Latency: word accepted in cycle t, first bit valid in cycle t+1.
- SHIFT:
  - out_val=1, out_bit=sreg[NBITS-1], out_last=(cnt==0).
  - On transfer (out_val && out_rdy): sreg <= {sreg[NBITS-2:0],1'b0} and cnt decrements.
  - If out_rdy=0, state, sreg, cnt and out_bit hold (stall); out_val stays high.
- Frame end:
  - On the transfer where out_last=1, with no new word accepted, return to IDLE.
  - in_rdy = out_last && out_rdy in SHIFT, giving back-to-back frames with zero bubble cycles.
  - If in_val is high in that cycle, load the new word, set cnt=NBITS-1 and stay in SHIFT.
- Throughput: one bit per cycle while out_rdy=1; NBITS cycles per word when streaming.
- Data stability: in_data is sampled only on the in_val && in_rdy cycle; later changes have no effect.
- Reset mid-frame: abort immediately; next cycle is IDLE with all outputs at reset values and the partial frame discarded.
- out_val must never depend combinationally on out_rdy. in_rdy may depend on out_rdy.

Optional Feature:
- Macro: SEQ_SREG_PISO_TX_PARITY_EN.
- When defined:
  - Each frame is NBITS+1 bits: the NBITS data bits, then one even-parity bit (XOR of the loaded word).
  - Parity is computed and registered at load.
  - out_last is asserted on the parity bit.
  - cnt width becomes $clog2(NBITS+1).
- When undefined: frame is exactly NBITS bits, with no parity logic and no parity register.

Decomposition:
- Shared package seq_sreg_pkg:
  - state enum typedef (IDLE, SHIFT);
  - default width constant SREG_NBITS=8;
  - function computing counter width.
- One sub-module: seq_sreg_piso_shreg, a load/shift register with ports clk, reset, load, load_data, shift, msb. The FSM and counter live in the top module.

Test Plan:
- Single word, out_rdy=1: in_data=8'hA5 at cycle 1 -> out_val high cycles 2-9, out_bit sequence 1,0,1,0,0,1,0,1, out_last only in cycle 9, in_rdy=1 in cycle 10.
- Back-to-back: 8'hFF then 8'h00 with in_val held -> 16 consecutive valid bits (eight 1s, then eight 0s), no bubble, second word accepted in the out_last cycle.
- Backpressure: 8'h81 with out_rdy low every other cycle -> out_bit holds while stalled, sequence 1,0,0,0,0,0,0,1, out_val never drops mid-frame.
- Reset mid-frame: reset after 3 bits of 8'hC3 -> next cycle out_val=0, out_bit=0, in_rdy=1; new word 8'h3C transmits cleanly.
- Loopback: drive a SISO 8-bit register (en=out_val&&out_rdy, sin=out_bit) with 8'h5A -> after frame the SISO contents equal 8'h5A.
- Parity (macro defined): 8'h07 -> 9 bits, last bit 1, out_last on bit 9; 8'h03 -> parity bit 0.
